countdown_timer: RTL and testbench
==================================

# countdown_timer

Parametrised countdown timer for the stopwatch/timer datapath. It runs from the single system clock with an internal tick prescaler, so it no longer needs a dedicated 1 Hz clock. It loads a user-set value, counts down one unit per tick, and supports pause, resume, restart and clear, with an optional auto-reload (periodic) mode. It sits between the debounced button/switch front-end and the seven-segment display driver.

## Interface
- WIDTH, 6: width of the load value and the count.
- TICK_DIV, 100_000_000: clock cycles per count tick; must be ≥ 1 (1 means a tick every RUN cycle).
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- seconds  in  WIDTH  load value; sampled only on start-from-IDLE/DONE, restart, and auto-reload.
- start  in  1  single-cycle pulse (debounced upstream).
- pause  in  1  single-cycle pulse.
- restart  in  1  single-cycle pulse.
- clear  in  1  single-cycle pulse.
- auto_reload  in  1  level; sampled at the terminal tick.
- countdown  out  WIDTH  current count.
- running  out  1  high while in RUN.
- done  out  1  one-cycle pulse on reaching terminal count.
- expired  out  1  high while in DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset: state IDLE, prescaler 0. countdown, running, done and expired are all 0.
- Command priority within one cycle: clear > restart > pause > start.
- clear (any state): countdown 0, prescaler 0, state IDLE.
- restart (any state):
  - seconds≠0: countdown←seconds, prescaler 0, state PAUSE (armed, not running).
  - seconds=0: countdown 0, state IDLE.
- start:
  - IDLE/DONE with seconds≠0: countdown←seconds, prescaler 0, state RUN.
  - IDLE/DONE with seconds=0: ignored.
  - PAUSE: resume to RUN; countdown and prescaler are unchanged.
  - RUN: ignored.
- pause: RUN→PAUSE, with the prescaler frozen at its current value. Ignored in other states.
- Tick: tick = (state==RUN) && (prescaler==TICK_DIV-1). In RUN the prescaler increments each cycle and wraps to 0 on tick. Outside RUN it holds.
- On tick with countdown>1: countdown decrements by 1.
- On tick with countdown==1:
  - done=1 for the next cycle.
  - auto_reload=1 and seconds≠0: countdown←seconds, stay RUN.
  - Otherwise: countdown←0, state DONE.
- Changes to seconds mid-run have no effect until the next load.
- Arithmetic is unsigned WIDTH bits. countdown never underflows because a tick is only taken from values ≥1.

## Timing
- All outputs are registered.
- start at cycle n: running=1 and countdown=seconds at n+1. The k-th decrement is visible at n+1+k·TICK_DIV.
- Terminal count: done/expired visible at n+1+seconds·TICK_DIV.
- Commands take effect at the edge that samples them. The prescaler does not advance on the cycle that pause is sampled.
- Resuming from PAUSE with the prescaler at p: next decrement is visible TICK_DIV−p cycles after the start edge.
- reset mid-operation overrides everything; all outputs are 0 on the next cycle.

## Structure
- Package countdown_pkg: state enum typedef (IDLE/RUN/PAUSE/DONE) and a prescaler-width helper constant ($clog2(TICK_DIV), minimum 1).
- Sub-module tick_prescaler:
  - Parameter DIV.
  - Inputs en, clr.
  - Output tick.
  - Holds its count when en=0.
- Top level: FSM plus the count register.

## Test plan
- WIDTH=6, TICK_DIV=4, seconds=3, start at cycle 0 -> countdown 3@1, 2@5, 1@9, 0@13. done=1 only @13. expired=1 and running=0 from 13.
- seconds=5, start@0, pause@6 -> countdown holds 4 while paused. start@s -> countdown 3 at s+4, then 2 at s+8.
- TICK_DIV=1, seconds=2, auto_reload=1, start@0 -> countdown 2,1,2,1… from cycle 1. done pulses @3, 5, 7. running stays 1.
- In RUN, clear and start in the same cycle -> IDLE, countdown 0. In DONE, restart with seconds=9 -> countdown 9, running 0, expired 0. A following start -> RUN.
- start with seconds=0 -> stays IDLE, countdown 0, no done. Change seconds mid-run -> count unaffected.
- reset asserted mid-RUN (countdown 3) -> next cycle countdown 0, running 0, done 0, expired 0. A subsequent start works normally.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// countdown_pkg: shared types and helpers for the countdown timer slice.
//   state_t        - timer FSM states (IDLE/RUN/PAUSE/DONE)
//   presc_width()  - bit width of the tick prescaler counter for a given
//                    divide ratio ($clog2(div), minimum 1)
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_WIDTH    = 6;
  localparam int unsigned DEFAULT_TICK_DIV = 100_000_000;

  function automatic int unsigned presc_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: command/status bundle between the button front-end,
// the countdown timer and the display driver.
//   seconds, start, pause, restart, clear, auto_reload : controller -> timer
//   countdown, running, done, expired                  : timer -> controller
// Modports: master (controller side), slave (timer side).
interface countdown_timer_if #(
  parameter int unsigned WIDTH = 6
);
  logic [WIDTH-1:0] seconds;
  logic             start;
  logic             pause;
  logic             restart;
  logic             clear;
  logic             auto_reload;
  logic [WIDTH-1:0] countdown;
  logic             running;
  logic             done;
  logic             expired;

  modport master (
    output seconds, start, pause, restart, clear, auto_reload,
    input  countdown, running, done, expired
  );

  modport slave (
    input  seconds, start, pause, restart, clear, auto_reload,
    output countdown, running, done, expired
  );
endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// tick_prescaler: divides the system clock into count ticks.
//   clock - system clock
//   reset - synchronous active-high reset (count -> 0)
//   en    - advance the count this cycle; the count holds when low
//   clr   - synchronous clear of the count (wins over en)
//   tick  - high on the enabled cycle where the count is DIV-1; the count
//           wraps to 0 on that same edge
module tick_prescaler
  import countdown_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    PW   = presc_width(DIV);
  localparam logic [PW-1:0]  LAST = PW'(DIV - 1);

  logic [PW-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with pause/resume/restart/clear and
// optional periodic auto-reload, ticking every TICK_DIV system clocks.
//   clock - system clock (rising edge)
//   reset - synchronous active-high reset
//   bus   - countdown_timer_if.slave: seconds/start/pause/restart/clear/
//           auto_reload in; countdown/running/done/expired out (registered)
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic               clock,
  input  logic               reset,
  countdown_timer_if.slave   bus
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic             running_q, done_q, expired_q;
  logic             done_nxt;
  logic             presc_en, presc_clr, tick;
  logic             seconds_nz;

  assign seconds_nz = (bus.seconds != '0);

  // Commands are resolved in priority order; the prescaler only advances on
  // a RUN cycle where no command overrides counting, so a sampled pause
  // freezes it without a final increment.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    done_nxt  = 1'b0;
    presc_en  = 1'b0;
    presc_clr = 1'b0;
    if (bus.clear) begin
      state_nxt = IDLE;
      count_nxt = '0;
      presc_clr = 1'b1;
    end else if (bus.restart) begin
      presc_clr = 1'b1;
      if (seconds_nz) begin
        state_nxt = PAUSE;
        count_nxt = bus.seconds;
      end else begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    end else if (bus.pause) begin
      if (state == RUN) state_nxt = PAUSE;
    end else if (bus.start && state != RUN) begin
      if (state == PAUSE) begin
        state_nxt = RUN;
      end else if (seconds_nz) begin
        state_nxt = RUN;
        count_nxt = bus.seconds;
        presc_clr = 1'b1;
      end
    end else if (state == RUN) begin
      presc_en = 1'b1;
      if (tick) begin
        if (count > WIDTH'(1)) begin
          count_nxt = count - 1'b1;
        end else begin
          done_nxt = 1'b1;
          if (bus.auto_reload && seconds_nz) begin
            count_nxt = bus.seconds;
          end else begin
            count_nxt = '0;
            state_nxt = DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      running_q <= (state_nxt == RUN);
      done_q    <= done_nxt;
      expired_q <= (state_nxt == DONE);
    end
  end

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .en    (presc_en),
    .clr   (presc_clr),
    .tick  (tick)
  );

  assign bus.countdown = count;
  assign bus.running   = running_q;
  assign bus.done      = done_q;
  assign bus.expired   = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] sec   = '0;
  logic       st = 1'b0, pa = 1'b0, rs = 1'b0, cl = 1'b0, ar = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state per instance (0: TICK_DIV=4, 1: TICK_DIV=1).
  int m_st[2], m_cnt[2], m_pre[2], m_div[2];
  bit m_done[2];

  always #5 clock = ~clock;

  countdown_timer_if #(.WIDTH(6)) bus0 ();
  countdown_timer_if #(.WIDTH(6)) bus1 ();

  assign bus0.seconds = sec;  assign bus1.seconds = sec;
  assign bus0.start   = st;   assign bus1.start   = st;
  assign bus0.pause   = pa;   assign bus1.pause   = pa;
  assign bus0.restart = rs;   assign bus1.restart = rs;
  assign bus0.clear   = cl;   assign bus1.clear   = cl;
  assign bus0.auto_reload = ar; assign bus1.auto_reload = ar;

  countdown_timer #(.WIDTH(6), .TICK_DIV(4)) dut0 (
    .clock (clock), .reset (reset), .bus (bus0)
  );
  countdown_timer #(.WIDTH(6), .TICK_DIV(1)) dut1 (
    .clock (clock), .reset (reset), .bus (bus1)
  );

  // {countdown, running, done, expired}
  logic [8:0] obs[2];
  assign obs[0] = {bus0.countdown, bus0.running, bus0.done, bus0.expired};
  assign obs[1] = {bus1.countdown, bus1.running, bus1.done, bus1.expired};

  function automatic logic [8:0] mvec(input int k);
    return {6'(m_cnt[k]), 1'(m_st[k] == M_RUN), 1'(m_done[k]), 1'(m_st[k] == M_DONE)};
  endfunction

  // One clock of the timer rules, evaluated on the sampled inputs.
  task automatic model_step(input int k);
    m_done[k] = 1'b0;
    if (reset) begin
      m_st[k] = M_IDLE; m_cnt[k] = 0; m_pre[k] = 0;
    end else if (cl) begin
      m_st[k] = M_IDLE; m_cnt[k] = 0; m_pre[k] = 0;
    end else if (rs) begin
      m_pre[k] = 0;
      if (sec != 0) begin m_cnt[k] = sec; m_st[k] = M_PAUSE; end
      else begin m_cnt[k] = 0; m_st[k] = M_IDLE; end
    end else if (pa) begin
      if (m_st[k] == M_RUN) m_st[k] = M_PAUSE;
    end else if (st && m_st[k] != M_RUN) begin
      if (m_st[k] == M_PAUSE) m_st[k] = M_RUN;
      else if (sec != 0) begin m_cnt[k] = sec; m_pre[k] = 0; m_st[k] = M_RUN; end
    end else if (m_st[k] == M_RUN) begin
      if (m_pre[k] == m_div[k] - 1) begin
        m_pre[k] = 0;
        if (m_cnt[k] > 1) m_cnt[k] = m_cnt[k] - 1;
        else begin
          m_done[k] = 1'b1;
          if (ar && sec != 0) m_cnt[k] = sec;
          else begin m_cnt[k] = 0; m_st[k] = M_DONE; end
        end
      end else begin
        m_pre[k] = m_pre[k] + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_step(0);
    model_step(1);
    #1;
    st = 1'b0; pa = 1'b0; rs = 1'b0; cl = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 9'h000) begin
        errors++;
        $display("FAIL reset inst%0d: got %h want 000", k, obs[k]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    cl = 1'b1; step();
    sec = 6'd3; st = 1'b1; step();
    for (int c = 1; c <= 16; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== mvec(k)) begin
          errors++;
          $display("FAIL basic_model inst%0d cyc%0d: got %h want %h", k, c, obs[k], mvec(k));
        end
      end
      if (c == 1 || c == 5 || c == 9 || c == 13) begin
        checks++;
        if (bus0.countdown !== 6'(3 - (c - 1) / 4)) begin
          errors++;
          $display("FAIL basic_count cyc%0d: got %0d want %0d", c, bus0.countdown, 3 - (c - 1) / 4);
        end
      end
      checks++;
      if (bus0.done !== (c == 13) || bus0.expired !== (c >= 13) || bus0.running !== (c < 13)) begin
        errors++;
        $display("FAIL basic_flags cyc%0d: got run=%b done=%b exp=%b", c, bus0.running, bus0.done, bus0.expired);
      end
      if (c < 16) step();
    end
  endtask

  task automatic test_pause();
    cl = 1'b1; step();
    sec = 6'd5; st = 1'b1; step();
    for (int c = 1; c <= 20; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== mvec(k)) begin
          errors++;
          $display("FAIL pause_model inst%0d cyc%0d: got %h want %h", k, c, obs[k], mvec(k));
        end
      end
      if (c >= 7 && c <= 12) begin
        checks++;
        if (bus0.countdown !== 6'd4 || bus0.running !== 1'b0) begin
          errors++;
          $display("FAIL pause_hold cyc%0d: got cnt=%0d run=%b want cnt=4 run=0", c, bus0.countdown, bus0.running);
        end
      end
      if (c == 16 || c == 20) begin
        checks++;
        if (bus0.countdown !== ((c == 16) ? 6'd3 : 6'd2)) begin
          errors++;
          $display("FAIL pause_resume cyc%0d: got cnt=%0d want %0d", c, bus0.countdown, (c == 16) ? 3 : 2);
        end
      end
      if (c == 6) pa = 1'b1;
      if (c == 12) st = 1'b1;
      if (c < 20) step();
    end
  endtask

  task automatic test_auto_reload();
    cl = 1'b1; step();
    ar = 1'b1; sec = 6'd2; st = 1'b1; step();
    for (int c = 1; c <= 8; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== mvec(k)) begin
          errors++;
          $display("FAIL reload_model inst%0d cyc%0d: got %h want %h", k, c, obs[k], mvec(k));
        end
      end
      checks++;
      if (bus1.countdown !== ((c % 2 == 1) ? 6'd2 : 6'd1) || bus1.running !== 1'b1 ||
          bus1.done !== (c >= 3 && c % 2 == 1)) begin
        errors++;
        $display("FAIL reload_seq cyc%0d: got cnt=%0d run=%b done=%b", c, bus1.countdown, bus1.running, bus1.done);
      end
      if (c < 8) step();
    end
    ar = 1'b0;
    cl = 1'b1; step();
  endtask

  task automatic test_commands();
    bit seen;
    cl = 1'b1; step();
    sec = 6'd9; st = 1'b1; step();
    step();
    cl = 1'b1; st = 1'b1; step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 9'h000 || obs[k] !== mvec(k)) begin
        errors++;
        $display("FAIL clear_over_start inst%0d: got %h want 000", k, obs[k]);
      end
    end
    sec = 6'd1; st = 1'b1; step();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus0.expired === 1'b1) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen || obs[0] !== mvec(0)) begin
      errors++;
      $display("FAIL wait_done: got exp=%b vec=%h want exp=1 vec=%h", bus0.expired, obs[0], mvec(0));
    end
    sec = 6'd9; rs = 1'b1; step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== {6'd9, 3'b000} || obs[k] !== mvec(k)) begin
        errors++;
        $display("FAIL restart_done inst%0d: got %h want %h", k, obs[k], {6'd9, 3'b000});
      end
    end
    st = 1'b1; step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== {6'd9, 3'b100} || obs[k] !== mvec(k)) begin
        errors++;
        $display("FAIL start_after_restart inst%0d: got %h want %h", k, obs[k], {6'd9, 3'b100});
      end
    end
    cl = 1'b1; step();
  endtask

  task automatic test_zero_and_seconds();
    cl = 1'b1; step();
    sec = 6'd0; st = 1'b1; step();
    for (int c = 1; c <= 4; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== 9'h000) begin
          errors++;
          $display("FAIL zero_start inst%0d cyc%0d: got %h want 000", k, c, obs[k]);
        end
      end
      step();
    end
    sec = 6'd4; st = 1'b1; step();
    sec = 6'd7;
    for (int c = 1; c <= 10; c++) begin
      checks++;
      if (bus0.countdown !== 6'(4 - (c - 1) / 4) || obs[0] !== mvec(0) || obs[1] !== mvec(1)) begin
        errors++;
        $display("FAIL seconds_midrun cyc%0d: got cnt=%0d want %0d", c, bus0.countdown, 4 - (c - 1) / 4);
      end
      step();
    end
  endtask

  task automatic test_reset_midrun();
    cl = 1'b1; step();
    sec = 6'd5; st = 1'b1; step();
    for (int c = 1; c < 9; c++) step();
    checks++;
    if (bus0.countdown !== 6'd3 || bus0.running !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: got cnt=%0d run=%b want cnt=3 run=1", bus0.countdown, bus0.running);
    end
    reset = 1'b1; step();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== 9'h000) begin
        errors++;
        $display("FAIL reset_mid inst%0d: got %h want 000", k, obs[k]);
      end
    end
    sec = 6'd5; st = 1'b1; step();
    checks++;
    if (obs[0] !== {6'd5, 3'b100}) begin
      errors++;
      $display("FAIL start_after_reset: got %h want %h", obs[0], {6'd5, 3'b100});
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 99);
      st = (r < 10);
      pa = (r >= 10 && r < 14);
      rs = (r >= 14 && r < 17);
      cl = (r >= 17 && r < 19);
      reset = (r == 19);
      if ($urandom_range(0, 15) == 0) sec = 6'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) ar = 1'($urandom_range(0, 1));
      step();
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== mvec(k)) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d: got %h want %h", k, c, obs[k], mvec(k));
        end
      end
    end
  endtask

  initial begin
    m_div[0] = 4;
    m_div[1] = 1;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = M_IDLE; m_cnt[k] = 0; m_pre[k] = 0; m_done[k] = 1'b0;
    end
    test_reset();
    test_basic();
    test_pause();
    test_auto_reload();
    test_commands();
    test_zero_and_seconds();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
